// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and taken-branch hazard detection.
// Hazard requests are combinational from the instruction in EX and the fields in ID.
// Saturating stall/flush event counters are kept for debug visibility.
module id_ex_stage #(
    parameter int unsigned i_size = 32,
    parameter int unsigned r_size = 5,
    parameter int unsigned c_size = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              id_mem_write,
    input  logic              id_memread,
    input  logic              id_ALUSrc,
    input  logic              id_regdst,
    input  logic              id_branch,
    input  logic [1:0]        id_ALUOp,
    input  logic [i_size-1:0] id_read_data1,
    input  logic [i_size-1:0] id_read_data2,
    input  logic [i_size-1:0] id_sign_ext,
    input  logic [i_size-1:0] id_pc_plus4,
    input  logic [r_size-1:0] id_rs,
    input  logic [r_size-1:0] id_rt,
    input  logic [r_size-1:0] id_rd,
    input  logic              ex_zero,
    output logic              ex_regwrite,
    output logic              ex_memtoreg,
    output logic              ex_mem_write,
    output logic              ex_memread,
    output logic              ex_ALUSrc,
    output logic              ex_regdst,
    output logic              ex_branch,
    output logic [1:0]        ex_ALUOp,
    output logic [i_size-1:0] ex_read_data1,
    output logic [i_size-1:0] ex_read_data2,
    output logic [i_size-1:0] ex_sign_ext,
    output logic [i_size-1:0] ex_pc_plus4,
    output logic [r_size-1:0] ex_rs,
    output logic [r_size-1:0] ex_rt,
    output logic [r_size-1:0] ex_rd,
    output logic              ID_flush_lw_stall,
    output logic              ID_flush_branch,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              if_flush,
    output logic [c_size-1:0] stall_cnt,
    output logic [c_size-1:0] flush_cnt
);

    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_mem_write;
    logic              r_memread;
    logic              r_alusrc;
    logic              r_regdst;
    logic              r_branch;
    logic [1:0]        r_aluop;
    logic [i_size-1:0] r_read_data1;
    logic [i_size-1:0] r_read_data2;
    logic [i_size-1:0] r_sign_ext;
    logic [i_size-1:0] r_pc_plus4;
    logic [r_size-1:0] r_rs;
    logic [r_size-1:0] r_rt;
    logic [r_size-1:0] r_rd;
    logic [c_size-1:0] r_stall_cnt;
    logic [c_size-1:0] r_flush_cnt;

    logic w_br_taken;
    logic w_lw_haz;
    logic w_lw_stall;
    logic w_bubble;

    // Hazard detection: a taken branch overrides a load-use stall since the
    // dependent younger instruction is discarded by the flush anyway.
    always_comb begin
        w_br_taken = r_branch & ex_zero;
        w_lw_haz   = r_memread & (r_rt != '0) & ((r_rt == id_rs) | (r_rt == id_rt));
        w_lw_stall = w_lw_haz & ~w_br_taken;
        w_bubble   = w_lw_stall | w_br_taken;
    end

    assign ID_flush_branch   = w_br_taken;
    assign ID_flush_lw_stall = w_lw_stall;
    assign if_flush          = w_br_taken;
    assign pc_write          = ~w_lw_stall;
    assign ifid_write        = ~w_lw_stall;

    // ID/EX register: capture ID each cycle, or load an all-zero bubble on a hazard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_memread    <= 1'b0;
            r_alusrc     <= 1'b0;
            r_regdst     <= 1'b0;
            r_branch     <= 1'b0;
            r_aluop      <= '0;
            r_read_data1 <= '0;
            r_read_data2 <= '0;
            r_sign_ext   <= '0;
            r_pc_plus4   <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
        end else if (w_bubble) begin
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_memread    <= 1'b0;
            r_alusrc     <= 1'b0;
            r_regdst     <= 1'b0;
            r_branch     <= 1'b0;
            r_aluop      <= '0;
            r_read_data1 <= '0;
            r_read_data2 <= '0;
            r_sign_ext   <= '0;
            r_pc_plus4   <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
        end else begin
            r_regwrite   <= id_regwrite;
            r_memtoreg   <= id_memtoreg;
            r_mem_write  <= id_mem_write;
            r_memread    <= id_memread;
            r_alusrc     <= id_ALUSrc;
            r_regdst     <= id_regdst;
            r_branch     <= id_branch;
            r_aluop      <= id_ALUOp;
            r_read_data1 <= id_read_data1;
            r_read_data2 <= id_read_data2;
            r_sign_ext   <= id_sign_ext;
            r_pc_plus4   <= id_pc_plus4;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rd         <= id_rd;
        end
    end

    // Event counters: count stall and flush cycles, holding at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lw_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_br_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign ex_regwrite   = r_regwrite;
    assign ex_memtoreg   = r_memtoreg;
    assign ex_mem_write  = r_mem_write;
    assign ex_memread    = r_memread;
    assign ex_ALUSrc     = r_alusrc;
    assign ex_regdst     = r_regdst;
    assign ex_branch     = r_branch;
    assign ex_ALUOp      = r_aluop;
    assign ex_read_data1 = r_read_data1;
    assign ex_read_data2 = r_read_data2;
    assign ex_sign_ext   = r_sign_ext;
    assign ex_pc_plus4   = r_pc_plus4;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus hazard detection. Sits directly downstream of the decode-stage control unit.
- Captures decoded control bits, register operands and immediates each cycle and presents them to EX.
- Generates the load-use stall and branch-flush requests (ID_flush_lw_stall, ID_flush_branch) that the control unit consumes to zero its outputs.
- Keeps saturating stall/flush event counters for debug.

Parameters:
i_size, 32, datapath width (operands, immediate, PC+4)
r_size, 5, register-address width
c_size, 16, event-counter width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset (0 = reset)
id_regwrite, id_memtoreg, id_mem_write, id_memread, id_ALUSrc, id_regdst, id_branch  in  1 each  decoded control bits
id_ALUOp  in  2  ALU operation class
id_read_data1, id_read_data2  in  i_size  register-file read data
id_sign_ext  in  i_size  sign-extended immediate
id_pc_plus4  in  i_size  PC+4 of the ID instruction
id_rs, id_rt, id_rd  in  r_size  register fields of the ID instruction
ex_zero  in  1  ALU zero flag of the instruction currently in EX
ex_regwrite, ex_memtoreg, ex_mem_write, ex_memread, ex_ALUSrc, ex_regdst, ex_branch  out  1 each  registered control
ex_ALUOp  out  2  registered ALU class
ex_read_data1, ex_read_data2, ex_sign_ext, ex_pc_plus4  out  i_size  registered data
ex_rs, ex_rt, ex_rd  out  r_size  registered register fields
ID_flush_lw_stall  out  1  load-use stall request (combinational)
ID_flush_branch  out  1  taken-branch flush request (combinational)
pc_write  out  1  PC enable; 0 freezes PC
ifid_write  out  1  IF/ID enable; 0 holds IF/ID
if_flush  out  1  clears IF/ID to a NOP
stall_cnt, flush_cnt  out  c_size  event counters

Behaviour:
- Reset: rst=0 asynchronously forces every registered output (all ex_*, stall_cnt, flush_cnt) to 0, with no clock edge needed. Release takes effect on the next rising clk.
- Branch taken: br_taken = ex_branch & ex_zero.
  - ID_flush_branch = br_taken.
  - if_flush = br_taken.
- Load-use: lw_haz = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - ID_flush_lw_stall = lw_haz & ~br_taken. Branch wins: the younger instructions are discarded anyway.
- Enables:
  - pc_write = ~ID_flush_lw_stall.
  - ifid_write = ~ID_flush_lw_stall.
  - During a branch flush, pc_write = 1 so the redirect loads.
- Register update on each rising clk with rst=1:
  - If ID_flush_lw_stall or ID_flush_branch is high, a bubble is inserted. All ex_* control bits, ex_ALUOp, data, PC and register fields load 0.
  - Otherwise all ex_* load their id_* counterparts.
  - Latency is exactly 1 cycle, ID to EX.
- Stall length: a load-use stall lasts exactly one cycle. The bubble clears ex_memread, so lw_haz falls on the following cycle while IF/ID still holds the dependent instruction.
- Counters:
  - stall_cnt increments by 1 on each clock edge where ID_flush_lw_stall = 1.
  - flush_cnt increments by 1 on each clock edge where ID_flush_branch = 1.
  - Both saturate at all-ones (0xFFFF) and never wrap.
- Register $0: a load with rt=0 never raises a stall.
- Simultaneous br_taken and lw_haz (only possible with malformed control): only the branch flush fires, stall_cnt does not increment, and flush_cnt does.
- Reset mid-stall: outputs clear immediately. The first edge after release behaves as a normal capture.

Test Plan:
1. Reset: drive rst=0 mid-cycle with id_regwrite=1 and id_read_data1=0xDEADBEEF. All ex_* and counters read 0 before the next edge. After release, the next edge gives ex_regwrite=1 and ex_read_data1=0xDEADBEEF.
2. Pass-through: an R-type ID (id_ALUOp=2'b10, id_regdst=1, id_rd=5'd9, id_read_data2=0x12) gives, one edge later, ex_ALUOp=2'b10, ex_regdst=1, ex_rd=9, ex_read_data2=0x12. pc_write=ifid_write=1.
3. Load-use: EX holds lw (ex_memread=1, ex_rt=8) and ID has id_rs=8. ID_flush_lw_stall=1 and pc_write=ifid_write=0. The next edge inserts a bubble (all ex_* = 0) and stall_cnt=1. The following cycle has no stall.
4. $0 load: ex_memread=1, ex_rt=0, id_rs=0 gives ID_flush_lw_stall=0, with normal capture and stall_cnt unchanged.
5. Branch: ex_branch=1 and ex_zero=1 give ID_flush_branch=1, if_flush=1, pc_write=1. The next edge inserts a bubble and flush_cnt increments. With ex_zero=0, no flush occurs.
6. Saturation/priority:
   - Preload flush_cnt to 0xFFFF via 65535 taken branches; one more branch keeps it at 0xFFFF.
   - Force br_taken and lw_haz together: only ID_flush_branch is high and stall_cnt is unchanged.
